// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin arbiter in front of memctl.
// Accepts single-beat read/write requests from two requesters over
// valid/ready, serializes them onto the memctl strobes and returns a
// one-cycle response pulse (with read data) to the granted requester.
//
// Ports:
//   clk, reset             clock, synchronous active-low reset
//   reqN_valid/write/addr/wdata, reqN_ready   request handshake, N = 0,1
//   rspN_valid/rdata                          response pulse and read data
//   mem_addr/wdata/write_en/read_en           strobes toward memctl
//   mem_rdata                                 read data from memctl
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic                  req0_write,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_ready,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  input  logic                  req1_valid,
  input  logic                  req1_write,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_ready,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_write_en,
  output logic                  mem_read_en,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  // Counter covers the full legal READ_LATENCY range of 1..15.
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t             state;
  logic               last_grant;
  logic               cur_id;
  logic               cur_write;
  logic [CNT_W-1:0]   cnt;

  logic                  grant;
  logic                  accept;
  logic                  sel_write;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  // Round-robin pick: a lone requester wins, a tie goes to the one not granted last.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  // Ready is forced low while reset is asserted, even though state is already IDLE.
  assign req0_ready = reset && (state == S_IDLE) && req0_valid && !grant;
  assign req1_ready = reset && (state == S_IDLE) && req1_valid && grant;
  assign accept     = req0_ready || req1_ready;

  // Fields of the winning requester.
  always_comb begin
    sel_write = req0_write;
    sel_addr  = req0_addr;
    sel_wdata = req0_wdata;
    if (grant) begin
      sel_write = req1_write;
      sel_addr  = req1_addr;
      sel_wdata = req1_wdata;
    end
  end

  // Control FSM; strobes and response pulses are registered so they line
  // up with the ISSUE and RESP states respectively.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_IDLE;
      last_grant   <= 1'b1;
      cur_id       <= 1'b0;
      cur_write    <= 1'b0;
      cnt          <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_write_en <= 1'b0;
      mem_read_en  <= 1'b0;
      rsp0_valid   <= 1'b0;
      rsp1_valid   <= 1'b0;
      rsp0_rdata   <= '0;
      rsp1_rdata   <= '0;
    end else begin
      mem_write_en <= 1'b0;
      mem_read_en  <= 1'b0;
      rsp0_valid   <= 1'b0;
      rsp1_valid   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            cur_id       <= grant;
            cur_write    <= sel_write;
            last_grant   <= grant;
            mem_addr     <= sel_addr;
            mem_wdata    <= sel_wdata;
            mem_write_en <= sel_write;
            mem_read_en  <= !sel_write;
            state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (cur_write) begin
            rsp0_valid <= !cur_id;
            rsp1_valid <= cur_id;
            state      <= S_RESP;
          end else begin
            cnt   <= CNT_W'(READ_LATENCY - 1);
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            if (cur_id) begin
              rsp1_rdata <= mem_rdata;
            end else begin
              rsp0_rdata <= mem_rdata;
            end
            rsp0_valid <= !cur_id;
            rsp1_valid <= cur_id;
            state      <= S_RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: bench for mem_arbiter. Instance 0 uses READ_LATENCY=1,
// instance 1 uses READ_LATENCY=3. Each instance has a memctl stand-in and a
// transaction-timeline model that is compared against every output each cycle.
module tb_mem_arbiter;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Stimulus, per instance.
  logic        v0 [2];
  logic        w0 [2];
  logic [15:0] a0 [2];
  logic [7:0]  d0 [2];
  logic        v1 [2];
  logic        w1 [2];
  logic [15:0] a1 [2];
  logic [7:0]  d1 [2];

  // DUT outputs, per instance.
  logic        rdy0 [2];
  logic        rdy1 [2];
  logic        rv0  [2];
  logic        rv1  [2];
  logic [7:0]  rd0  [2];
  logic [7:0]  rd1  [2];
  logic [15:0] maddr [2];
  logic [7:0]  mwd  [2];
  logic        mwe  [2];
  logic        mre  [2];

  int gq [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input int inst, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL inst%0d %s: got 0x%0h expected 0x%0h (cycle %0d)",
               inst, name, act, exp, cyc);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_i
    localparam int unsigned LAT = (gi == 0) ? 1 : 3;

    logic [7:0] mrd;

    mem_arbiter #(
      .ADDR_WIDTH  (16),
      .DATA_WIDTH  (8),
      .READ_LATENCY(LAT)
    ) dut (
      .clk         (clk),
      .reset       (rst_n),
      .req0_valid  (v0[gi]),
      .req0_write  (w0[gi]),
      .req0_addr   (a0[gi]),
      .req0_wdata  (d0[gi]),
      .req0_ready  (rdy0[gi]),
      .rsp0_valid  (rv0[gi]),
      .rsp0_rdata  (rd0[gi]),
      .req1_valid  (v1[gi]),
      .req1_write  (w1[gi]),
      .req1_addr   (a1[gi]),
      .req1_wdata  (d1[gi]),
      .req1_ready  (rdy1[gi]),
      .rsp1_valid  (rv1[gi]),
      .rsp1_rdata  (rd1[gi]),
      .mem_addr    (maddr[gi]),
      .mem_wdata   (mwd[gi]),
      .mem_write_en(mwe[gi]),
      .mem_read_en (mre[gi]),
      .mem_rdata   (mrd)
    );

    // memctl stand-in: read data is valid only in the cycle LAT after read_en,
    // 0xEE at all other times so a mistimed capture shows up.
    logic [7:0] envmem [65536];
    int         rd_due = -1;
    logic [7:0] rd_pend;

    always @(negedge clk) begin
      if (rst_n !== 1'b1 && gi == 1) envmem[16'h00FF] = 8'h3C;
      if (mwe[gi] === 1'b1) envmem[maddr[gi]] = mwd[gi];
      if (mre[gi] === 1'b1) begin
        rd_due  = cyc + int'(LAT);
        rd_pend = envmem[maddr[gi]];
      end
      mrd = (cyc == rd_due) ? rd_pend : 8'hEE;
    end

    // Timeline model: an accepted request at cycle ta strobes in ta+1 and
    // responds in ta+2 (write) or ta+2+LAT (read); idle again the cycle after.
    logic [7:0]  mmem [65536];
    bit          mvalid = 0;
    bit          act = 0;
    bit          m_id;
    bit          m_wr;
    bit          last;
    int          ta;
    int          r_cyc;
    logic [15:0] m_addr;
    logic [15:0] e_maddr;
    logic [7:0]  e_mwd;
    logic [7:0]  e_rd0;
    logic [7:0]  e_rd1;

    always @(negedge clk) begin
      bit e_rdy0, e_rdy1, e_iss, e_rsp;
      e_rdy0 = 0;
      e_rdy1 = 0;
      if (mvalid) begin
        if (act && cyc > r_cyc) act = 0;
        e_iss = act && (cyc == ta + 1);
        e_rsp = act && (cyc == r_cyc);
        if (e_rsp && !m_wr) begin
          if (m_id) e_rd1 = mmem[m_addr];
          else      e_rd0 = mmem[m_addr];
        end
        e_rdy0 = (rst_n === 1'b1) && !act && v0[gi] && (!v1[gi] || last);
        e_rdy1 = (rst_n === 1'b1) && !act && v1[gi] && (!v0[gi] || !last);
        check(gi, "req0_ready",   32'(rdy0[gi]),  32'(e_rdy0));
        check(gi, "req1_ready",   32'(rdy1[gi]),  32'(e_rdy1));
        check(gi, "mem_write_en", 32'(mwe[gi]),   32'(e_iss && m_wr));
        check(gi, "mem_read_en",  32'(mre[gi]),   32'(e_iss && !m_wr));
        check(gi, "mem_addr",     32'(maddr[gi]), 32'(e_maddr));
        check(gi, "mem_wdata",    32'(mwd[gi]),   32'(e_mwd));
        check(gi, "rsp0_valid",   32'(rv0[gi]),   32'(e_rsp && !m_id));
        check(gi, "rsp1_valid",   32'(rv1[gi]),   32'(e_rsp && m_id));
        check(gi, "rsp0_rdata",   32'(rd0[gi]),   32'(e_rd0));
        check(gi, "rsp1_rdata",   32'(rd1[gi]),   32'(e_rd1));
      end
      if (rst_n !== 1'b1) begin
        if (gi == 1) mmem[16'h00FF] = 8'h3C;
        mvalid  = 1;
        act     = 0;
        last    = 1;
        e_maddr = '0;
        e_mwd   = '0;
        e_rd0   = '0;
        e_rd1   = '0;
      end else if (mvalid && (e_rdy0 || e_rdy1)) begin
        m_id    = e_rdy1;
        m_wr    = m_id ? w1[gi] : w0[gi];
        m_addr  = m_id ? a1[gi] : a0[gi];
        e_mwd   = m_id ? d1[gi] : d0[gi];
        e_maddr = m_addr;
        last    = m_id;
        act     = 1;
        ta      = cyc;
        r_cyc   = cyc + (m_wr ? 2 : 2 + int'(LAT));
        if (m_wr) mmem[m_addr] = e_mwd;
      end
    end
  end

  // Grant order seen on instance 0.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (rdy0[0] && v0[0]) gq.push_back(0);
      if (rdy1[0] && v1[0]) gq.push_back(1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input int i, input int id, input logic wr,
                        input logic [15:0] a, input logic [7:0] d,
                        output int tacc);
    bit got = 0;
    tacc = -1;
    if (id == 0) begin v0[i] = 1; w0[i] = wr; a0[i] = a; d0[i] = d; end
    else         begin v1[i] = 1; w1[i] = wr; a1[i] = a; d1[i] = d; end
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if ((id == 0) ? rdy0[i] : rdy1[i]) begin
        got  = 1;
        tacc = cyc;
      end
      step();
    end
    if (id == 0) v0[i] = 0; else v1[i] = 0;
    if (!got) check(i, "accept_timeout", 32'(0), 32'(1));
  endtask

  task automatic wait_rsp(input int i, input int id, output int trsp);
    bit got = 0;
    trsp = -1;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if ((id == 0) ? rv0[i] : rv1[i]) begin
        got  = 1;
        trsp = cyc;
      end
      step();
    end
    if (!got) check(i, "rsp_timeout", 32'(0), 32'(1));
  endtask

  initial begin
    int ta, tr;
    bit acc0;
    for (int i = 0; i < 2; i++) begin
      v0[i] = 0; w0[i] = 0; a0[i] = '0; d0[i] = '0;
      v1[i] = 0; w1[i] = 0; a1[i] = '0; d1[i] = '0;
    end
    rst_n = 1'b0;
    // Reset held with both requesters valid; req0 writes, req1 reads back.
    v0[0] = 1; w0[0] = 1; a0[0] = 16'h0010; d0[0] = 8'hA5;
    v1[0] = 1; w1[0] = 0; a1[0] = 16'h0010; d1[0] = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check(0, "lit_rst_ready0", 32'(rdy0[0]), 32'(0));
    check(0, "lit_rst_ready1", 32'(rdy1[0]), 32'(0));
    check(0, "lit_rst_we",     32'(mwe[0]),  32'(0));
    check(0, "lit_rst_re",     32'(mre[0]),  32'(0));
    check(0, "lit_rst_addr",   32'(maddr[0]), 32'(0));
    check(0, "lit_rst_rv0",    32'(rv0[0]),  32'(0));
    check(0, "lit_rst_rdata1", 32'(rd1[0]),  32'(0));
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check(0, "lit_first_ready0", 32'(rdy0[0]), 32'(1));
    check(0, "lit_first_ready1", 32'(rdy1[0]), 32'(0));
    step();
    v0[0] = 0;
    @(negedge clk);
    check(0, "lit_wr_we",    32'(mwe[0]),   32'(1));
    check(0, "lit_wr_re",    32'(mre[0]),   32'(0));
    check(0, "lit_wr_addr",  32'(maddr[0]), 32'(16'h0010));
    check(0, "lit_wr_wdata", 32'(mwd[0]),   32'(8'hA5));
    step();
    @(negedge clk);
    check(0, "lit_wr_we_off", 32'(mwe[0]), 32'(0));
    check(0, "lit_wr_rsp0",   32'(rv0[0]), 32'(1));
    check(0, "lit_busy_rdy1", 32'(rdy1[0]), 32'(0));
    step();
    @(negedge clk);
    check(0, "lit_rd_ready1", 32'(rdy1[0]), 32'(1));
    step();
    v1[0] = 0;
    @(negedge clk);
    check(0, "lit_rd_re",   32'(mre[0]),   32'(1));
    check(0, "lit_rd_addr", 32'(maddr[0]), 32'(16'h0010));
    step();
    @(negedge clk);
    check(0, "lit_rd_wait_rsp1", 32'(rv1[0]), 32'(0));
    step();
    @(negedge clk);
    check(0, "lit_rd_rsp1",   32'(rv1[0]), 32'(1));
    check(0, "lit_rd_rdata1", 32'(rd1[0]), 32'(8'hA5));
    check(0, "lit_rd_rdata0", 32'(rd0[0]), 32'(0));
    step();

    // Continuous contention: req0 writes 0x20, req1 reads it back.
    gq.delete();
    v0[0] = 1; w0[0] = 1; a0[0] = 16'h0020; d0[0] = 8'h5A;
    v1[0] = 1; w1[0] = 0; a1[0] = 16'h0020;
    for (int k = 0; k < 300 && gq.size() < 6; k++) begin
      @(negedge clk);
      acc0 = rdy0[0] && v0[0];
      step();
      if (acc0) d0[0] = d0[0] + 8'h11;
    end
    v0[0] = 0;
    v1[0] = 0;
    check(0, "lit_grant_count", 32'(gq.size()), 32'(6));
    for (int k = 0; k < 6 && k < gq.size(); k++) begin
      check(0, $sformatf("lit_grant_%0d", k), 32'(gq[k]), 32'(k % 2));
    end
    wait_rsp(0, 1, tr);
    check(0, "lit_cont_rdata1", 32'(rd1[0]), 32'(8'h7C));

    // Reset during WAIT of a read: no response, clean restart.
    do_req(0, 1, 1'b0, 16'h0020, 8'h00, ta);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check(0, "lit_midrst_rsp1", 32'(rv1[0]),   32'(0));
    check(0, "lit_midrst_addr", 32'(maddr[0]), 32'(0));
    check(0, "lit_midrst_re",   32'(mre[0]),   32'(0));
    step();
    repeat (3) step();
    do_req(0, 0, 1'b0, 16'h0010, 8'h00, ta);
    wait_rsp(0, 0, tr);
    check(0, "lit_after_rst_lat",   32'(tr - ta), 32'(3));
    check(0, "lit_after_rst_rdata", 32'(rd0[0]),  32'(8'hA5));

    // READ_LATENCY = 3 instance.
    do_req(1, 0, 1'b0, 16'h00FF, 8'h00, ta);
    wait_rsp(1, 0, tr);
    check(1, "lit_lat3_rd_lat",   32'(tr - ta), 32'(5));
    check(1, "lit_lat3_rd_rdata", 32'(rd0[1]),  32'(8'h3C));
    do_req(1, 1, 1'b1, 16'h0040, 8'h77, ta);
    wait_rsp(1, 1, tr);
    check(1, "lit_lat3_wr_lat", 32'(tr - ta), 32'(2));
    do_req(1, 0, 1'b0, 16'h0040, 8'h00, ta);
    wait_rsp(1, 0, tr);
    check(1, "lit_lat3_rd2_lat",   32'(tr - ta), 32'(5));
    check(1, "lit_lat3_rd2_rdata", 32'(rd0[1]),  32'(8'h77));
    check(1, "lit_lat3_rdata1",    32'(rd1[1]),  32'(0));

    repeat (4) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
